lvds_frame_tx: RTL

Framed nibble-wide transmitter for the 4-lane LVDS link. It accepts a byte stream over a valid/ready handshake and emits framed nibbles on `lane_out[3:0]`, which feed the four `OBUFDS` lane drivers at top level. Each frame is a preamble, a start-of-frame nibble, the payload (low nibble first), and an 8-bit additive checksum. It is the sending end for the board's LVDS input path, replacing the plain input-to-output loopback as the source of `lvds_out`.

---
 rtl/lvds_frame_tx_if.sv | 9 +
 rtl/lvds_frame_tx.sv | 99 +++++++++
 2 files changed

// File: rtl/lvds_frame_tx_if.sv
// lvds_frame_tx_if: byte-stream valid/ready handshake feeding the LVDS frame transmitter
interface lvds_frame_tx_if;
  logic [7:0] s_data;
  logic s_valid;
  logic s_last;
  logic s_ready;
  modport master (output s_data, s_valid, s_last, input s_ready);
  modport slave (input s_data, s_valid, s_last, output s_ready);
endinterface

// File: rtl/lvds_frame_tx.sv
// lvds_frame_tx: frames a byte stream into preamble/SOF/payload/checksum nibbles on four LVDS lanes
module lvds_frame_tx #(
  parameter int PREAMBLE_LEN = 4,
  parameter int GAP_LEN = 8,
  parameter int MAX_LEN = 256,
  parameter logic [3:0] IDLE_NIBBLE = 4'h0
) (
  input  logic clk,
  input  logic rst,
  lvds_frame_tx_if.slave s,
  output logic [3:0] lane_out,
  output logic busy,
  output logic frame_done,
  output logic underrun,
  output logic len_err
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int CMAX = PREAMBLE_LEN > GAP_LEN ? PREAMBLE_LEN : GAP_LEN;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [3:0] IDLE = 4'd0, PRE = 4'd1, SOF = 4'd2, DLO = 4'd3, DHI = 4'd4;
  localparam logic [3:0] CLO = 4'd5, CHI = 4'd6, ABORT = 4'd7, DRAIN = 4'd8, GAP = 4'd9;
  logic [3:0] st, nx, lane_nx;
  logic [CW-1:0] cnt;
  logic [LW-1:0] nbytes;
  logic [7:0] byte_q, csum;
  logic last_q, trunc_q, go, in_frame, acc, at_max;
  assign in_frame = st == SOF || (st == DHI && !last_q);
  assign s.s_ready = in_frame || st == DRAIN;
  assign acc = in_frame && s.s_valid;
  assign at_max = nbytes == LW'(MAX_LEN - 1);
  // state holds what the lanes show this cycle; outputs register the next state's view
  always_comb begin
    nx = st;
    case (st)
      IDLE: nx = go ? PRE : IDLE;
      PRE: nx = cnt == CW'(PREAMBLE_LEN - 1) ? SOF : PRE;
      SOF, DHI: nx = (st == DHI && last_q) ? CLO : s.s_valid ? DLO : ABORT;
      DLO: nx = DHI;
      CLO: nx = CHI;
      CHI: nx = trunc_q ? DRAIN : GAP;
      ABORT: nx = DRAIN;
      DRAIN: nx = (s.s_valid && s.s_last) ? GAP : DRAIN;
      GAP: nx = cnt == CW'(GAP_LEN - 1) ? IDLE : GAP;
      default: nx = IDLE;
    endcase
  end
  always_comb begin
    lane_nx = IDLE_NIBBLE;
    case (nx)
      PRE: lane_nx = 4'h5;
      SOF: lane_nx = 4'hD;
      DLO: lane_nx = s.s_data[3:0];
      DHI: lane_nx = byte_q[7:4];
      CLO: lane_nx = csum[3:0];
      CHI: lane_nx = csum[7:4];
      ABORT: lane_nx = 4'hF;
      default: lane_nx = IDLE_NIBBLE;
    endcase
  end
  // go delays the start decision by one cycle so a held s_valid leaves exactly one idle cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      cnt <= '0;
      nbytes <= '0;
      byte_q <= '0;
      csum <= '0;
      last_q <= 1'b0;
      trunc_q <= 1'b0;
      go <= 1'b0;
      lane_out <= IDLE_NIBBLE;
      busy <= 1'b0;
      frame_done <= 1'b0;
      underrun <= 1'b0;
      len_err <= 1'b0;
    end else begin
      st <= nx;
      cnt <= nx != st ? '0 : cnt + 1'b1;
      go <= s.s_valid;
      if (nx == PRE && st != PRE) begin
        csum <= '0;
        nbytes <= '0;
        last_q <= 1'b0;
        trunc_q <= 1'b0;
      end else if (acc) begin
        byte_q <= s.s_data;
        csum <= csum + s.s_data;
        nbytes <= nbytes + 1'b1;
        last_q <= s.s_last || at_max;
        trunc_q <= !s.s_last && at_max;
      end
      lane_out <= lane_nx;
      busy <= nx != IDLE;
      frame_done <= nx == CHI;
      underrun <= nx == ABORT;
      len_err <= nx == CHI && trunc_q;
    end
  end
endmodule
